gb_lcd_pattern_tx: RTL and testbench

GB_LCD_PATTERN_TX -- requirements
Module: gb_lcd_pattern_tx

---
 rtl/gb_lcd_pattern_tx.sv | 140 ++++++++++++++
 tb/tb_gb_lcd_pattern_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_lcd_pattern_tx.sv
// Game Boy style LCD timing generator with selectable test patterns.
// Dot ticks come from a free-running prescaler; all outputs are registered from next-state values.
module gb_lcd_pattern_tx #(
  parameter int CLK_DIV      = 4,
  parameter int LINE_TICKS   = 456,
  parameter int HS_TICKS     = 8,
  parameter int ACTIVE_LINES = 144,
  parameter int TOTAL_LINES  = 154
) (
  input  logic       CLK_16MHz,
  input  logic       RESET_N,
  input  logic       ENABLE,
  input  logic [1:0] MODE,
  input  logic [1:0] SHADE,
  output logic [1:0] GB_DAT,
  output logic       GB_PX_CLK,
  output logic       GB_HSYNC,
  output logic       GB_VSYNC,
  output logic       FRAME_START
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = $clog2(LINE_TICKS);
  localparam int LW = (TOTAL_LINES > 1) ? $clog2(TOTAL_LINES) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PRE_HALF  = PW'(CLK_DIV / 2);
  localparam logic [TW-1:0] TICK_LAST = TW'(LINE_TICKS - 1);
  localparam logic [TW-1:0] HS_T      = TW'(HS_TICKS);
  localparam logic [LW-1:0] LINE_LAST = LW'(TOTAL_LINES - 1);
  localparam logic [LW-1:0] ACT_L     = LW'(ACTIVE_LINES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [TW-1:0] tick_reg, tick_next;
  logic [LW-1:0] line_reg, line_next;
  logic [1:0]    mode_reg, mode_next;
  logic [1:0]    shade_reg, shade_next;
  logic          frame_start_next;
  logic [1:0]    dat_next;
  logic          px_clk_next, hsync_next, vsync_next;
  logic          dot_end;
  logic          in_win;
  logic [15:0]   x_full;
  logic [1:0]    xb, yb;

  always_ff @(posedge CLK_16MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg   <= IDLE;
      presc_reg   <= '0;
      tick_reg    <= '0;
      line_reg    <= '0;
      mode_reg    <= '0;
      shade_reg   <= '0;
      GB_DAT      <= '0;
      GB_PX_CLK   <= 1'b0;
      GB_HSYNC    <= 1'b0;
      GB_VSYNC    <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      state_reg   <= state_next;
      presc_reg   <= presc_next;
      tick_reg    <= tick_next;
      line_reg    <= line_next;
      mode_reg    <= mode_next;
      shade_reg   <= shade_next;
      GB_DAT      <= dat_next;
      GB_PX_CLK   <= px_clk_next;
      GB_HSYNC    <= hsync_next;
      GB_VSYNC    <= vsync_next;
      FRAME_START <= frame_start_next;
    end
  end

  // A new dot tick begins on the edge where the prescaler wraps to 0.
  always_comb begin
    dot_end          = (presc_reg == PRE_LAST);
    state_next       = state_reg;
    presc_next       = dot_end ? '0 : presc_reg + 1'b1;
    tick_next        = tick_reg;
    line_next        = line_reg;
    mode_next        = mode_reg;
    shade_next       = shade_reg;
    frame_start_next = 1'b0;
    case (state_reg)
      IDLE: begin
        tick_next = '0;
        line_next = '0;
        if (dot_end && ENABLE) begin
          state_next       = RUN;
          frame_start_next = 1'b1;
        end
      end
      RUN: begin
        if (dot_end) begin
          if (tick_reg == TICK_LAST) begin
            tick_next = '0;
            if (line_reg == LINE_LAST) begin
              line_next = '0;
              if (ENABLE) frame_start_next = 1'b1;
              else        state_next       = IDLE;
            end else begin
              line_next = line_reg + 1'b1;
            end
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (frame_start_next) begin
      mode_next  = MODE;
      shade_next = SHADE;
    end
  end

  // Ticks before HS_TICKS wrap x_full to a huge value, so one compare bounds the window.
  always_comb begin
    x_full      = 16'(tick_next) - 16'(HS_TICKS);
    xb          = x_full[4:3];
    yb          = 2'(line_next >> 3);
    in_win      = (state_next == RUN) && (line_next < ACT_L) && (x_full < 16'd160);
    px_clk_next = in_win && (presc_next < PRE_HALF);
    hsync_next  = (state_next == RUN) && (tick_next < HS_T);
    vsync_next  = (state_next == RUN) && (line_next == '0);
    dat_next    = 2'b00;
    if (in_win) begin
      case (mode_next)
        2'd0:    dat_next = shade_next;
        2'd1:    dat_next = xb;
        2'd2:    dat_next = yb;
        default: dat_next = {2{xb[0] ^ yb[0]}};
      endcase
    end
  end

endmodule

// File: tb/tb_gb_lcd_pattern_tx.sv
// Bench for gb_lcd_pattern_tx: per-cycle comparison against a time-offset reference model,
// per-frame statistics and a table of pattern sample points.
module tb_gb_lcd_pattern_tx;

  localparam int CD = 4;
  localparam int LT = 170;
  localparam int HS = 8;
  localparam int AL = 10;
  localparam int TL = 12;
  localparam int LINE_CYC  = CD * LT;
  localparam int FRAME_CYC = LINE_CYC * TL;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] mode, shade;
  logic [1:0] gb_dat;
  logic       gb_px_clk, gb_hsync, gb_vsync, frame_start;

  always #5 clk = ~clk;

  gb_lcd_pattern_tx #(
    .CLK_DIV(CD), .LINE_TICKS(LT), .HS_TICKS(HS), .ACTIVE_LINES(AL), .TOTAL_LINES(TL)
  ) dut (
    .CLK_16MHz(clk), .RESET_N(rst_n), .ENABLE(enable), .MODE(mode), .SHADE(shade),
    .GB_DAT(gb_dat), .GB_PX_CLK(gb_px_clk), .GB_HSYNC(gb_hsync), .GB_VSYNC(gb_vsync),
    .FRAME_START(frame_start)
  );

  typedef struct {
    logic [1:0] md;
    int         x;
    int         y;
    logic [1:0] exp;
  } vec_t;

  vec_t vecs[23];

  int checks = 0;
  int errors = 0;

  // Reference model state: edges since reset release, frame start edge, latched controls.
  int         k;
  bit         m_run;
  int         m_start;
  logic [1:0] m_mode, m_shade;

  bit px_last, px_cur;
  int fs_cnt, vs_cnt;
  int hs_cnt[TL];
  int falls[TL];
  logic [1:0] cap[AL][160];

  function automatic logic [1:0] pat(input logic [1:0] md, input logic [1:0] sh, input int x, input int y);
    logic c;
    c = x[3] ^ y[3];
    case (md)
      2'd0:    return sh;
      2'd1:    return x[4:3];
      2'd2:    return y[4:3];
      default: return {c, c};
    endcase
  endfunction

  function automatic int m_line();
    return (k - m_start) / LINE_CYC;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    check(name, int'({gb_dat, gb_px_clk, gb_hsync, gb_vsync, frame_start}), 0);
  endtask

  task automatic model_reset();
    k = 0; m_run = 0; m_start = 0; m_mode = 0; m_shade = 0;
    px_last = 0; px_cur = 0;
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic step();
    int t, p, dot, tick, line, x;
    bit win;
    logic [5:0] exp, act;
    @(posedge clk);
    k++;
    if (m_run && (k - m_start) == FRAME_CYC) begin
      if (enable) begin m_start = k; m_mode = mode; m_shade = shade; end
      else m_run = 0;
    end else if (!m_run && (k % CD) == 0 && enable) begin
      m_run = 1; m_start = k; m_mode = mode; m_shade = shade;
    end
    #1;
    exp = '0;
    if (m_run) begin
      t    = k - m_start;
      p    = t % CD;
      dot  = t / CD;
      tick = dot % LT;
      line = dot / LT;
      x    = tick - HS;
      win  = (line < AL) && (tick >= HS) && (tick < HS + 160);
      exp[5:4] = win ? pat(m_mode, m_shade, x, line) : 2'b00;
      exp[3]   = win && (p < CD / 2);
      exp[2]   = (tick < HS);
      exp[1]   = (line == 0);
      exp[0]   = (t == 0);
    end
    act = {gb_dat, gb_px_clk, gb_hsync, gb_vsync, frame_start};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cycle k=%0d t=%0d: got dat/px/hs/vs/fs=%b expected %b", k, k - m_start, act, exp);
    end
    px_last = px_cur;
    px_cur  = gb_px_clk;
  endtask

  task automatic accum();
    int dot, line, x;
    dot  = (k - m_start) / CD;
    line = dot / LT;
    x    = (dot % LT) - HS;
    if (line >= TL) return;
    fs_cnt += int'(frame_start);
    vs_cnt += int'(gb_vsync);
    hs_cnt[line] += int'(gb_hsync);
    if (px_last && !px_cur) begin
      falls[line]++;
      if (line < AL && x >= 0 && x < 160) cap[line][x] = gb_dat;
    end
  endtask

  task automatic wait_fs(input string name, input int bound, output int waited);
    waited = 0;
    while (frame_start !== 1'b1 && waited < bound) begin
      step();
      waited++;
    end
    check(name, int'(frame_start === 1'b1), 1);
  endtask

  // Runs one frame starting at the sample where FRAME_START is high.
  task automatic run_frame(input int idx, input logic [1:0] nmode, input logic [1:0] nshade,
                           input bit nen, input int junk_line, input int junk_mode, input int drop_line);
    logic [1:0] fmode, fshade;
    int bad_hs, bad_falls, bad_vec, nv;
    fmode = m_mode; fshade = m_shade;
    fs_cnt = 0; vs_cnt = 0;
    for (int l = 0; l < TL; l++) begin hs_cnt[l] = 0; falls[l] = 0; end
    for (int y = 0; y < AL; y++) for (int x = 0; x < 160; x++) cap[y][x] = 2'bxx;
    accum();
    fs_cnt = 0;
    for (int s = 1; s <= FRAME_CYC; s++) begin
      if (s - 1 == junk_line * LINE_CYC) begin
        mode  = (junk_mode < 0) ? 2'($urandom) : 2'(junk_mode);
        shade = 2'($urandom);
      end
      if (s - 1 == drop_line * LINE_CYC) enable = 1'b0;
      if (s - 1 == (TL - 1) * LINE_CYC) begin mode = nmode; shade = nshade; enable = nen; end
      step();
      if (s < FRAME_CYC) accum();
    end
    check("frame_start_mid_frame", fs_cnt, 0);
    check("vsync_cycles", vs_cnt, LINE_CYC);
    bad_hs = 0; bad_falls = 0;
    for (int l = 0; l < TL; l++) begin
      if (hs_cnt[l] != HS * CD) bad_hs++;
      if (falls[l] != ((l < AL) ? 160 : 0)) bad_falls++;
    end
    check("hsync_lines_bad", bad_hs, 0);
    check("px_fall_lines_bad", bad_falls, 0);
    bad_vec = 0; nv = 0;
    for (int i = 0; i < 23; i++) begin
      if (vecs[i].md == fmode) begin
        nv++;
        checks++;
        if (cap[vecs[i].y][vecs[i].x] !== vecs[i].exp) begin
          errors++; bad_vec++;
          $display("FAIL pattern mode=%0d x=%0d y=%0d: got %b expected %b", fmode, vecs[i].x, vecs[i].y,
                   cap[vecs[i].y][vecs[i].x], vecs[i].exp);
        end
      end
    end
    $display("frame %0d mode=%0d shade=%0d vsync=%0d vectors=%0d bad_vectors=%0d", idx, fmode, fshade,
             vs_cnt, nv, bad_vec);
  endtask

  initial begin
    int waited, n;
    vecs[0]  = '{2'd0, 0, 0, 2'd2};    vecs[1]  = '{2'd0, 159, 9, 2'd2};  vecs[2]  = '{2'd0, 80, 5, 2'd2};
    vecs[3]  = '{2'd1, 0, 0, 2'd0};    vecs[4]  = '{2'd1, 7, 3, 2'd0};    vecs[5]  = '{2'd1, 8, 3, 2'd1};
    vecs[6]  = '{2'd1, 15, 6, 2'd1};   vecs[7]  = '{2'd1, 16, 9, 2'd2};   vecs[8]  = '{2'd1, 24, 1, 2'd3};
    vecs[9]  = '{2'd1, 31, 2, 2'd3};   vecs[10] = '{2'd1, 32, 4, 2'd0};   vecs[11] = '{2'd1, 159, 8, 2'd3};
    vecs[12] = '{2'd2, 5, 0, 2'd0};    vecs[13] = '{2'd2, 100, 7, 2'd0};  vecs[14] = '{2'd2, 0, 8, 2'd1};
    vecs[15] = '{2'd2, 159, 9, 2'd1};  vecs[16] = '{2'd3, 0, 8, 2'd3};    vecs[17] = '{2'd3, 7, 8, 2'd3};
    vecs[18] = '{2'd3, 8, 8, 2'd0};    vecs[19] = '{2'd3, 0, 0, 2'd0};    vecs[20] = '{2'd3, 8, 0, 2'd3};
    vecs[21] = '{2'd3, 8, 7, 2'd3};    vecs[22] = '{2'd3, 16, 9, 2'd3};

    rst_n = 1'b0; enable = 1'b0; mode = 2'd0; shade = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_zero_outputs("reset_outputs");
    @(negedge clk) rst_n = 1'b1;

    // Idle with random control churn: nothing may appear on the outputs.
    for (int i = 0; i < 200; i++) begin
      mode = 2'($urandom); shade = 2'($urandom);
      step();
    end
    check("idle_no_frame_start", int'(m_run), 0);

    mode = 2'd0; shade = 2'b10; enable = 1'b1;
    wait_fs("first_frame_start", 2 * CD, waited);
    run_frame(0, 2'd1, 2'($urandom), 1'b1, $urandom_range(1, TL - 2), -1, -1);
    run_frame(1, 2'd2, 2'($urandom), 1'b1, $urandom_range(1, TL - 2), -1, -1);
    run_frame(2, 2'd3, 2'($urandom), 1'b1, $urandom_range(1, TL - 2), -1, -1);
    run_frame(3, 2'd0, 2'b10,        1'b1, $urandom_range(1, TL - 2), -1, -1);
    run_frame(4, 2'd2, 2'($urandom), 1'b1, 7, 2, -1);
    run_frame(5, 2'd1, 2'($urandom), 1'b0, $urandom_range(1, 4), -1, 5);

    // After the drop the block must sit idle with silent outputs.
    n = 0;
    for (int i = 0; i < 500; i++) begin
      mode = 2'($urandom);
      step();
      n += int'(frame_start);
    end
    check("idle_after_drop_fs", n, 0);
    check_zero_outputs("idle_after_drop_outputs");

    enable = 1'b1;
    wait_fs("restart_frame_start", 2 * CD, waited);
    waited = 0;
    while (!(gb_px_clk === 1'b1 && m_line() >= 1) && waited < 3 * LINE_CYC) begin
      step();
      waited++;
    end
    check("px_clk_high_found", int'(gb_px_clk === 1'b1), 1);

    // Reset mid-pixel must clear outputs without waiting for a clock edge.
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("async_reset_outputs");
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_zero_outputs("reset_hold_outputs");
    @(negedge clk) rst_n = 1'b1;
    wait_fs("post_reset_frame_start", 4, waited);
    check("post_reset_fs_within_4", int'(waited <= 4), 1);
    for (int i = 0; i < 2 * LINE_CYC; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
